// File: rtl/ram_addr_pkg.sv
// Shared constants and helpers for the lab RAM address controllers.
// Holds the default geometries of the 30-word and 40-word lab RAMs.
package ram_addr_pkg;

  localparam int unsigned RAM30_DEPTH      = 30;
  localparam int unsigned RAM30_ADDR_WIDTH = 6;
  localparam int unsigned RAM40_DEPTH      = 40;
  localparam int unsigned RAM40_ADDR_WIDTH = 6;

  // Count must hold DEPTH itself, which can equal 2^ADDR_WIDTH.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Pointer register that increments on demand and wraps from DEPTH-1 back to 0.
// Used for both the read and the write pointer of ram_address_controller.
module wrap_counter #(
  parameter int unsigned DEPTH      = 30,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] value
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == LAST) ? '0 : value + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ram_address_controller.sv
// Circular-buffer address generator: wrapping read/write pointers, occupancy, flags, error pulses.
// Build option: define RAM_ADDR_OVERWRITE_EN to let a write into a full buffer discard the oldest word.
module ram_address_controller
  import ram_addr_pkg::*;
#(
  parameter  int unsigned DEPTH       = RAM30_DEPTH,
  parameter  int unsigned ADDR_WIDTH  = RAM30_ADDR_WIDTH,
  localparam int unsigned COUNT_WIDTH = count_width(ADDR_WIDTH)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   WriteRequest,
  input  logic                   ReadRequest,
  output logic [ADDR_WIDTH-1:0]  WriteAddress,
  output logic [ADDR_WIDTH-1:0]  ReadAddress,
  output logic                   WriteEnable,
  output logic                   ReadValid,
  output logic [COUNT_WIDTH-1:0] Count,
  output logic                   Full,
  output logic                   Empty,
  output logic                   Overflow,
  output logic                   Underflow
);

  logic drop_oldest;
  logic advance_read;

  assign Full  = (Count == COUNT_WIDTH'(DEPTH));
  assign Empty = (Count == '0);

  // NOTE: every output of this block gets a value on every path, so no latch is inferred.
  always_comb begin
    ReadValid = ReadRequest & ~Empty;
`ifdef RAM_ADDR_OVERWRITE_EN
    WriteEnable = WriteRequest;
    drop_oldest = WriteRequest & Full & ~ReadValid;
`else
    WriteEnable = WriteRequest & (~Full | ReadValid);
    drop_oldest = 1'b0;
`endif
    advance_read = ReadValid | drop_oldest;
  end

  wrap_counter #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_write_ptr (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (WriteEnable),
    .value (WriteAddress)
  );

  wrap_counter #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_read_ptr (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (advance_read),
    .value (ReadAddress)
  );

  // An overwrite is a write plus an implicit read, so occupancy is unchanged.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Count <= '0;
    end else if (WriteEnable & ~ReadValid & ~drop_oldest) begin
      Count <= Count + COUNT_WIDTH'(1);
    end else if (ReadValid & ~WriteEnable) begin
      Count <= Count - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Overflow  <= (WriteRequest & ~WriteEnable) | drop_oldest;
      Underflow <= ReadRequest & Empty;
    end
  end

endmodule
